// File: rtl/accel_filter_pkg.sv
// Shared defaults and width helpers for the accelerometer block-averaging filter.
package accel_filter_pkg;

  localparam int DEF_DATA_W   = 10;
  localparam int DEF_LOG2_WIN = 4;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_CH_W     = 2;

  // The accumulator holds up to 2^log2_win non-negative samples of data_w-1 bits.
  function automatic int acc_width(input int data_w, input int log2_win);
    return data_w - 1 + log2_win;
  endfunction

endpackage

// File: rtl/accel_avg_chan.sv
// Single-channel window accumulator: sums conditioned samples and flags the
// last sample of each power-of-two window. The sum output already includes
// the current sample, so the parent can form the average in the same cycle.
module accel_avg_chan
  import accel_filter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOG2_WIN = DEF_LOG2_WIN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic [DATA_W-2:0]            sample,
  output logic                         done,
  output logic [DATA_W+LOG2_WIN-2:0]   sum
);

  localparam int ACC_W = acc_width(DATA_W, LOG2_WIN);
  localparam logic [LOG2_WIN-1:0] CNT_ONE = LOG2_WIN'(1);

  logic [ACC_W-1:0]    acc_reg;
  logic [LOG2_WIN-1:0] cnt_reg;

  // The worst-case window sum fits ACC_W bits, so no carry-out is needed.
  assign sum  = acc_reg + {{LOG2_WIN{1'b0}}, sample};
  assign done = en && (cnt_reg == '1);

  // Accumulate each accepted sample; restart the window after its last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (en) begin
      if (done) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= sum;
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/accel_avg_filter.sv
// Multi-channel block-averaging filter. Conditions signed samples (negatives
// clamp to zero), routes them to per-channel accumulators, and registers the
// window average with its channel tag as a one-cycle valid pulse.
// Optional build macro FILTER_ROUND_EN: round-half-up instead of floor.
module accel_avg_filter
  import accel_filter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOG2_WIN = DEF_LOG2_WIN,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CH_W     = DEF_CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [CH_W-1:0]   sample_chan,
  input  logic [DATA_W-1:0] sample_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_chan,
  output logic [DATA_W-2:0] out_data,
  output logic              overflow
);

  localparam int ACC_W = acc_width(DATA_W, LOG2_WIN);
  // One extra bit so a channel count equal to 2^CH_W is representable.
  localparam logic [CH_W:0] CHAN_LIM = (CH_W+1)'(CHANNELS);

  logic [DATA_W-2:0]   cond_sample;
  logic                chan_ok;
  logic                accept;
  logic [CHANNELS-1:0] en_vec;
  logic [CHANNELS-1:0] done_vec;
  logic [ACC_W-1:0]    sum_arr [CHANNELS];
  logic [ACC_W-1:0]    sum_sel;
  logic                done_any;
  logic [DATA_W-2:0]   result;

  logic                out_valid_reg;
  logic [CH_W-1:0]     out_chan_reg;
  logic [DATA_W-2:0]   out_data_reg;
  logic                overflow_reg;

  assign cond_sample = sample_data[DATA_W-1] ? '0 : sample_data[DATA_W-2:0];
  assign chan_ok     = ({1'b0, sample_chan} < CHAN_LIM);
  // Clear takes priority, so a sample arriving with it never reaches a channel.
  assign accept      = sample_valid && !clear && chan_ok;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign en_vec[gi] = accept && (sample_chan == CH_W'(gi));

      accel_avg_chan #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN)
      ) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clear),
        .en     (en_vec[gi]),
        .sample (cond_sample),
        .done   (done_vec[gi]),
        .sum    (sum_arr[gi])
      );
    end
  endgenerate

  // Select the completing channel's sum; at most one channel is enabled per cycle.
  always_comb begin
    done_any = 1'b0;
    sum_sel  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (en_vec[c]) begin
        done_any = done_any | done_vec[c];
        sum_sel  = sum_sel | sum_arr[c];
      end
    end
  end

`ifdef FILTER_ROUND_EN
  localparam logic [ACC_W:0] RND_ADD = (ACC_W+1)'(1) << (LOG2_WIN-1);
  logic [ACC_W:0] rnd_sum;
  logic           unused_rnd;
  assign rnd_sum    = {1'b0, sum_sel} + RND_ADD;
  assign result     = rnd_sum[LOG2_WIN +: DATA_W-1];
  // The top bit is never set for legal sums; fractional bits are discarded.
  assign unused_rnd = ^{rnd_sum[ACC_W], rnd_sum[LOG2_WIN-1:0]};
`else
  logic unused_frac;
  assign result      = sum_sel[LOG2_WIN +: DATA_W-1];
  assign unused_frac = ^sum_sel[LOG2_WIN-1:0];
`endif

  // Output registers: pulse on window completion, hold tag/data until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_chan_reg  <= '0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= done_any;
      if (done_any) begin
        out_chan_reg <= sample_chan;
        out_data_reg <= result;
      end
    end
  end

  // Sticky flag for samples tagged with a channel that does not exist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (clear) begin
      overflow_reg <= 1'b0;
    end else if (sample_valid && !chan_ok) begin
      overflow_reg <= 1'b1;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_chan  = out_chan_reg;
  assign out_data  = out_data_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_accel_avg_filter.sv
// Self-checking bench for accel_avg_filter (default parameters).
module tb_accel_avg_filter;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       sample_valid;
  logic [1:0] sample_chan;
  logic [9:0] sample_data;
  logic       out_valid;
  logic [1:0] out_chan;
  logic [8:0] out_data;
  logic       overflow;

  accel_avg_filter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample_chan  (sample_chan),
    .sample_data  (sample_data),
    .out_valid    (out_valid),
    .out_chan     (out_chan),
    .out_data     (out_data),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0] ch;
    logic [8:0] data;
    int         due;
  } exp_t;
  exp_t sbq[$];
  logic [8:0] last_data = '0;

  // Window vectors: 8 samples of a followed by 8 samples of b on one channel.
  typedef struct {
    logic [1:0] ch;
    logic [9:0] a;
    logic [9:0] b;
    logic [8:0] exp_trunc;
    logic [8:0] exp_round;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [9:0] d, input logic clr);
    @(negedge clk);
    sample_valid = v;
    sample_chan  = ch;
    sample_data  = d;
    clear        = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 10'd0, 1'b0);
  endtask

  // Called right after driving a window's final sample.
  task automatic expect_out(input logic [1:0] ch, input logic [8:0] data);
    exp_t e;
    e.ch = ch;
    e.data = data;
    e.due = cyc + 1;
    sbq.push_back(e);
    last_data = data;
    $display("push: chan=%0d data=%0d due=%0d", ch, data, e.due);
  endtask

  task automatic run_window(input logic [1:0] ch, input logic [9:0] a, input logic [9:0] b,
                            input logic [8:0] exp_val);
    for (int i = 0; i < 16; i++) drive(1'b1, ch, (i < 8) ? a : b, 1'b0);
    expect_out(ch, exp_val);
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_valid", int'(out_valid), 0);
      end else begin
        e = sbq.pop_front();
        $display("out: chan=%0d data=%0d cycle=%0d", out_chan, out_data, cyc);
        chk("pulse_cycle", cyc, e.due);
        chk("out_chan", int'(out_chan), int'(e.ch));
        chk("out_data", int'(out_data), int'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] rr_val [3];
    logic [8:0] rnd_exp;

    tbl[0] = '{2'd0, 10'd200,  10'd200, 9'd200, 9'd200};
    tbl[1] = '{2'd1, 10'h3FB,  10'd100, 9'd50,  9'd50};
    tbl[2] = '{2'd2, 10'd511,  10'd511, 9'd511, 9'd511};
    tbl[3] = '{2'd0, 10'd0,    10'd1,   9'd0,   9'd1};
    tbl[4] = '{2'd1, 10'd3,    10'd4,   9'd3,   9'd4};
    tbl[5] = '{2'd2, 10'h200,  10'd511, 9'd255, 9'd256};
    tbl[6] = '{2'd0, 10'd100,  10'd101, 9'd100, 9'd101};

    rst_n = 1'b0;
    clear = 1'b0;
    sample_valid = 1'b0;
    sample_chan = '0;
    sample_data = '0;
    idle(3);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_chan",  int'(out_chan),  0);
    chk("reset_out_data",  int'(out_data),  0);
    chk("reset_overflow",  int'(overflow),  0);
    rst_n = 1'b1;
    idle(2);

    // Table-driven windows.
    for (int t = 0; t < 7; t++) begin
`ifdef FILTER_ROUND_EN
      run_window(tbl[t].ch, tbl[t].a, tbl[t].b, tbl[t].exp_round);
`else
      run_window(tbl[t].ch, tbl[t].a, tbl[t].b, tbl[t].exp_trunc);
`endif
      idle(2);
    end

    // Round-robin interleave; completions land on consecutive cycles.
    rr_val[0] = 10'd10;
    rr_val[1] = 10'd300;
    rr_val[2] = 10'd511;
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 3; c++) begin
        drive(1'b1, 2'(c), rr_val[c], 1'b0);
        if (i == 15) expect_out(2'(c), rr_val[c][8:0]);
      end
    end
    idle(2);

    // Rounding corner: sum of 8 over 16 samples.
`ifdef FILTER_ROUND_EN
    rnd_exp = 9'd1;
`else
    rnd_exp = 9'd0;
`endif
    for (int i = 0; i < 16; i++) drive(1'b1, 2'd2, (i == 15) ? 10'd8 : 10'd0, 1'b0);
    expect_out(2'd2, rnd_exp);
    idle(2);

    // Clear mid-window, with a same-cycle sample that must be dropped.
    for (int i = 0; i < 10; i++) drive(1'b1, 2'd0, 10'd400, 1'b0);
    drive(1'b1, 2'd0, 10'd400, 1'b1);
    drive(1'b1, 2'd0, 10'd20, 1'b0);
    chk("clear_holds_data", int'(out_data), int'(last_data));
    chk("clear_no_valid", int'(out_valid), 0);
    for (int i = 1; i < 16; i++) drive(1'b1, 2'd0, 10'd20, 1'b0);
    expect_out(2'd0, 9'd20);
    idle(2);

    // Asynchronous reset right after a completion, with a partial window pending on ch1.
    for (int i = 0; i < 10; i++) drive(1'b1, 2'd1, 10'd400, 1'b0);
    run_window(2'd0, 10'd400, 10'd400, 9'd400);
    @(posedge clk);
    #2;
    chk("pre_reset_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    chk("async_reset_valid", int'(out_valid), 0);
    chk("async_reset_data",  int'(out_data),  0);
    chk("async_reset_chan",  int'(out_chan),  0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    run_window(2'd1, 10'd20, 10'd20, 9'd20);
    idle(2);

    // Invalid channel: dropped, sticky flag, cleared only by clear.
    drive(1'b1, 2'd3, 10'd100, 1'b0);
    idle(1);
    chk("overflow_set", int'(overflow), 1);
    run_window(2'd0, 10'd0, 10'd0, 9'd0);
    idle(2);
    chk("overflow_sticky", int'(overflow), 1);
    drive(1'b0, 2'd0, 10'd0, 1'b1);
    idle(1);
    chk("overflow_cleared", int'(overflow), 0);

    idle(5);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
